uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit-side counterpart of the UART receive path.
- Accepts a byte over a valid/ready handshake and serializes it onto the TX line, LSB first.
- Frame: start bit, 8 data bits, optional parity bit, then 1 or 2 stop bits.
- Bit timing comes from an external oversampling tick shared with the receiver's baud generator; the block sits between the TL-UL register file and the pad.

Parameters:
- OVERSAMPLE, 16: i_tick pulses per bit period; legal range 4..32.
- CNT_W, 5: width of the tick counter; must satisfy 2^CNT_W >= OVERSAMPLE.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset.
- i_tick  input  1  oversample enable, one-cycle pulse.
- i_tx_valid  input  1  byte available.
- i_tx_data  input  8  byte to send.
- o_tx_ready  output  1  block can accept a byte.
- i_parity_en  input  1  insert parity bit.
- i_parity_odd  input  1  1 = odd parity, 0 = even parity.
- i_two_stop  input  1  1 = two stop bits.
- o_tx_serial  output  1  serial line, idle high.
- o_tx_busy  output  1  frame in progress.
- o_tx_done  output  1  one-cycle pulse at end of frame.

Interface rule:
- One clock; reset is synchronous and active-high.
- Clock port is i_clk, reset port is i_rst.

Behaviour:
- Reset values: o_tx_serial=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0; state=IDLE, tick counter=0, bit index=0, shift register=0.
- A reset asserted mid-frame aborts the frame. o_tx_serial returns to 1 on the next edge and no o_tx_done is issued.
- States, 3-bit encoding: IDLE=000, START=001, DATA=010, PARITY=011, STOP_I=100, STOP_II=101.
- o_tx_ready=1 only in IDLE. o_tx_busy is the inverse of o_tx_ready.
- Accept: in IDLE, when i_tx_valid && o_tx_ready:
  - Latch i_tx_data, i_parity_en, i_parity_odd and i_two_stop.
  - Clear the tick counter and move to START on the next edge.
  - Config inputs are ignored for the rest of the frame.
- o_tx_serial is registered and reflects the state of the current cycle:
  - START drives 0.
  - DATA drives data[bit index].
  - PARITY drives ^data ^ parity_odd.
  - STOP_I, STOP_II and IDLE drive 1.
- Bit period:
  - The tick counter increments on each i_tick.
  - A bit ends on the cycle where i_tick=1 and counter==OVERSAMPLE-1; the counter then wraps to 0.
  - Cycles without i_tick hold all state.
- Transitions at bit end:
  - START -> DATA.
  - DATA: bit index increments; after index 7, go to PARITY if parity is enabled, else STOP_I. The index wraps to 0.
  - PARITY -> STOP_I.
  - STOP_I -> STOP_II if two stop bits are selected, else IDLE.
  - STOP_II -> IDLE.
- Frame end:
  - o_tx_done pulses for exactly one cycle, coincident with the first IDLE cycle.
  - o_tx_ready is 1 in that same cycle.
- Back-to-back: if i_tx_valid is held, the next byte is accepted in the first IDLE cycle. The inter-frame gap is exactly 1 clock of line-high beyond the stop bits.
- Frame length in bit periods: 10, +1 with parity, +1 with two stop bits.
- i_tick asserted while in IDLE has no effect.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- With the macro defined, the block adds port i_break (input, 1 bit):
  - While i_break=1 and state=IDLE, o_tx_serial is forced to 0 and o_tx_ready=0.
  - A frame in progress completes normally before the break takes effect.
  - On i_break deassertion the line returns to 1 and stays high for one full bit period before o_tx_ready=1.
- Without the macro, the port does not exist and the line is never forced low outside START.

Test Plan:
- Basic frame: OVERSAMPLE=16, i_tick=1 every cycle, send 0xA5 with no parity and 1 stop bit -> line is 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles; o_tx_done pulses 160 cycles after accept.
- Parity: send 0x07 with even parity -> parity bit 1; send 0x07 with odd parity -> parity bit 0; each frame is 176 cycles.
- Two stop bits: send 0x00 with two stop bits and no parity -> 8 low data bits, then the line is high for 32 cycles before o_tx_done.
- Back-to-back: hold i_tx_valid with 0x55 then 0xAA -> second start bit falls 1 cycle after the first o_tx_done, and no byte is lost.
- Tick gating: i_tick every 4th cycle, send 0x81 -> each bit lasts 64 cycles; config changes made mid-frame do not alter the frame in flight.
- Reset: assert i_rst during DATA bit 3 -> next cycle o_tx_serial=1, o_tx_ready=1, no o_tx_done pulse; with UART_TX_BREAK_EN, i_break held 100 cycles in IDLE -> line low for 100 cycles, then high with o_tx_ready=1 after 16 further cycles.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends start, 8 data bits (LSB first),
// an optional parity bit and 1 or 2 stop bits. Define UART_TX_BREAK_EN to add the i_break line-break input.
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  input  logic       i_parity_en,
  input  logic       i_parity_odd,
  input  logic       i_two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic       i_break,
`endif
  output logic       o_tx_serial,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_START   = 3'b001,
    ST_DATA    = 3'b010,
    ST_PARITY  = 3'b011,
    ST_STOP_I  = 3'b100,
    ST_STOP_II = 3'b101
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             two_stop_q, two_stop_d;
  logic             serial_q, serial_d;
  logic             ready_q, ready_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef UART_TX_BREAK_EN
  logic             brk_q, brk_d;
  logic             hold_q, hold_d;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    done_d     = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_d      = brk_q;
    hold_d     = hold_q;
`endif
    bit_end    = i_tick && (cnt_q == CNT_LAST);
    if ((state_q != ST_IDLE) && i_tick) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (ready_q && i_tx_valid) begin
          shift_d    = i_tx_data;
          par_en_d   = i_parity_en;
          par_bit_d  = parity_bit(i_tx_data, i_parity_odd);
          two_stop_d = i_two_stop;
          cnt_d      = '0;
          idx_d      = 3'd0;
          state_d    = ST_START;
        end
`ifdef UART_TX_BREAK_EN
        else if (i_break) begin
          brk_d  = 1'b1;
          hold_d = 1'b0;
          cnt_d  = '0;
        end else if (brk_q) begin
          // After a break the line must idle high for a whole bit before the next frame.
          brk_d  = 1'b0;
          hold_d = 1'b1;
          cnt_d  = '0;
        end else if (hold_q && i_tick) begin
          if (cnt_q == CNT_LAST) begin
            hold_d = 1'b0;
            cnt_d  = '0;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
`endif
        else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP_I;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP_I;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP_I: begin
        if (bit_end) begin
          state_d = two_stop_q ? ST_STOP_II : ST_IDLE;
          done_d  = !two_stop_q;
        end else begin
          state_d = ST_STOP_I;
        end
      end
      ST_STOP_II: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_STOP_II;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level is derived from the next state so the registered output matches the state it is in.
    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = shift_d[0];
      ST_PARITY: serial_d = par_bit_d;
      default:   serial_d = 1'b1;
    endcase
    ready_d = (state_d == ST_IDLE);
`ifdef UART_TX_BREAK_EN
    if ((state_d == ST_IDLE) && brk_d) begin
      serial_d = 1'b0;
    end else begin
      serial_d = serial_d;
    end
    ready_d = ready_d && !brk_d && !hold_d;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      serial_q   <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q      <= 1'b0;
      hold_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      serial_q   <= serial_d;
      ready_q    <= ready_d;
      busy_q     <= ~ready_d;
      done_q     <= done_d;
`ifdef UART_TX_BREAK_EN
      brk_q      <= brk_d;
      hold_q     <= hold_d;
`endif
    end
  end

  assign o_tx_serial = serial_q;
  assign o_tx_ready  = ready_q;
  assign o_tx_busy   = busy_q;
  assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a driver queues expected frames, a monitor decodes the line.
module tb_uart_tx_serializer;
  localparam int OS = 16;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       valid;
  logic [7:0] data;
  logic       pen, podd, two;
  logic       serial, ready, busy, done;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  typedef struct {
    logic [11:0] bits;
    int          n;
    logic [7:0]  d;
  } frame_t;

  frame_t exp_q[$];
  int     vectors     = 0;
  int     miscompares = 0;
  int     tick_mode   = 0;
  int     cyc         = 0;
  bit     mon_busy    = 1'b0;

  uart_tx_serializer #(.OVERSAMPLE(OS), .CNT_W(5)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_tick       (tick),
    .i_tx_valid   (valid),
    .i_tx_data    (data),
    .o_tx_ready   (ready),
    .i_parity_en  (pen),
    .i_parity_odd (podd),
    .i_two_stop   (two),
`ifdef UART_TX_BREAK_EN
    .i_break      (brk),
`endif
    .o_tx_serial  (serial),
    .o_tx_busy    (busy),
    .o_tx_done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick pattern: 0 = every cycle, 1 = every 4th cycle, 2 = random.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (tick_mode)
        0:       tick = 1'b1;
        1:       tick = ((cyc % 4) == 0);
        default: tick = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference frame: list of line levels, one per bit period.
  function automatic frame_t model(input logic [7:0] d, input logic pe, input logic po, input logic ts);
    frame_t f;
    int     k;
    int     ones;
    f.bits = '0;
    f.d    = d;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
    k = 9;
    ones = $countones(d);
    if (pe) begin
      f.bits[k] = po ? ((ones % 2) == 0) : ((ones % 2) == 1);
      k++;
    end
    f.bits[k] = 1'b1;
    k++;
    if (ts) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.n = k;
    return f;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_frame(input frame_t f, output bit aborted);
    aborted = 1'b0;
    for (int b = 0; b < f.n; b++) begin
      int   ticks  = 0;
      int   cycles = 0;
      bit   bad    = 1'b0;
      logic g_ser = 1'b0, g_rdy = 1'b0, g_bsy = 1'b0, g_dn = 1'b0;
      while (ticks < OS) begin
        @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          return;
        end
        cycles++;
        if (!bad && (serial !== f.bits[b] || ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0)) begin
          bad = 1'b1;
          g_ser = serial; g_rdy = ready; g_bsy = busy; g_dn = done;
        end
        if (tick) ticks++;
        if (cycles > 64 * OS) begin
          bad   = 1'b1;
          ticks = OS;
        end
      end
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL frame_bit%0d data=0x%02h: line=%b ready=%b busy=%b done=%b, expected line=%b ready=0 busy=1 done=0",
                 b, f.d, g_ser, g_rdy, g_bsy, g_dn, f.bits[b]);
      end
    end
    @(negedge clk);
    if (rst) begin
      aborted = 1'b1;
      return;
    end
    vectors++;
    if (done !== 1'b1 || ready !== 1'b1 || serial !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_end data=0x%02h: done=%b ready=%b line=%b busy=%b, expected 1 1 1 0",
               f.d, done, ready, serial, busy);
    end
  endtask

  // Monitor: pops an expected frame on every accepted byte and checks the line against it.
  initial begin
    bit     acc;
    bit     aborted;
    frame_t f;
    forever begin
      @(negedge clk);
      if (rst) continue;
      acc = ready && valid;
      if (!acc) begin
        vectors++;
        if (done !== 1'b0 || busy !== !ready) begin
          miscompares++;
          $display("FAIL idle_outputs: done=%b busy=%b ready=%b, expected done=0 busy=~ready", done, busy, ready);
        end
      end
      while (acc) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_accept: accept seen with empty scoreboard, expected none");
          acc = 1'b0;
        end else begin
          f        = exp_q.pop_front();
          mon_busy = 1'b1;
          check_frame(f, aborted);
          mon_busy = 1'b0;
          acc      = !aborted && !rst && ready && valid;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic po, input logic ts);
    int w = 0;
    data  = d;
    pen   = pe;
    podd  = po;
    two   = ts;
    valid = 1'b1;
    exp_q.push_back(model(d, pe, po, ts));
    do begin
      @(negedge clk);
      w++;
    end while (!ready && w < 20000);
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: ready=%b after %0d cycles, expected 1", ready, w);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = 8'($urandom);
    pen   = 1'($urandom);
    podd  = 1'($urandom);
    two   = 1'($urandom);
  endtask

  task automatic measure_done(input string name, input int exp);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < 5000);
    chk(name, n, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data = 8'h00; pen = 1'b0; podd = 1'b0; two = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_serial", int'(serial), 1);
    chk("reset_ready",  int'(ready),  1);
    chk("reset_busy",   int'(busy),   0);
    chk("reset_done",   int'(done),   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    tick_mode = 0;
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    measure_done("len_basic", 160);
    idle(2);
    send(8'h07, 1'b1, 1'b0, 1'b0);
    measure_done("len_even_parity", 176);
    idle(2);
    send(8'h07, 1'b1, 1'b1, 1'b0);
    measure_done("len_odd_parity", 176);
    idle(2);
    send(8'h00, 1'b0, 1'b0, 1'b1);
    measure_done("len_two_stop", 176);
    send(8'h55, 1'b0, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0, 1'b0);
    tick_mode = 1;
    send(8'h81, 1'b0, 1'b0, 1'b0);

    // Abort during data bit 3 of an all-zero byte.
    tick_mode = 0;
    send(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (69) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_reset_line", int'(serial), 0);
    @(negedge clk);
    chk("abort_serial", int'(serial), 1);
    chk("abort_ready",  int'(ready),  1);
    chk("abort_busy",   int'(busy),   0);
    chk("abort_done",   int'(done),   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(200);

    for (int i = 0; i < 40; i++) begin
      tick_mode = $urandom_range(0, 2);
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      idle($urandom_range(0, 3));
    end

`ifdef UART_TX_BREAK_EN
    begin
      int w = 0;
      while ((exp_q.size() != 0 || mon_busy || !ready) && w < 5000) begin
        @(posedge clk);
        w++;
      end
      #1;
    end
    tick_mode = 0;
    brk = 1'b1;
    fork
      begin
        repeat (100) @(posedge clk);
        #1;
        brk = 1'b0;
      end
      begin
        int lo = 0;
        int hi = 0;
        int w  = 0;
        int ok = 1;
        @(negedge clk);
        while (serial !== 1'b0 && w < 8) begin
          @(negedge clk);
          w++;
        end
        while (serial === 1'b0 && lo < 400) begin
          if (ready !== 1'b0) ok = 0;
          lo++;
          @(negedge clk);
        end
        chk("break_low_cycles", lo, 100);
        while (ready !== 1'b1 && hi < 400) begin
          if (serial !== 1'b1) ok = 0;
          hi++;
          @(negedge clk);
        end
        chk("break_recover_cycles", hi, 16);
        chk("break_levels", ok, 1);
      end
    join
`endif

    begin
      int w = 0;
      while ((exp_q.size() != 0 || mon_busy) && w < 20000) begin
        @(posedge clk);
        w++;
      end
      chk("drain_pending", exp_q.size() + int'(mon_busy), 0);
    end
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
